// File: rtl/key_filter_pkg.sv
// Shared types and helpers for the key_filter push-button conditioner.
package key_filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_FILT,
        DOWN,
        LONG_HELD,
        REL_FILT
    } key_state_e;

    // Counter width large enough to hold the largest of the three cycle thresholds.
    function automatic int unsigned cnt_width(input int unsigned deb_cycles,
                                              input int unsigned long_cycles,
                                              input int unsigned rep_cycles);
        int unsigned max_cycles;
        max_cycles = deb_cycles;
        if (long_cycles > max_cycles) max_cycles = long_cycles;
        if (rep_cycles > max_cycles) max_cycles = rep_cycles;
        if (max_cycles < 2) return 1;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce/long-press FSM and registered event outputs.
// Auto-repeat in LONG_HELD is built only when KEY_FILTER_REPEAT_EN is defined.
module key_filter_ch
    import key_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 540_000,
    parameter int unsigned LONG_PRESS_CYCLES = 13_500_000,
    parameter int unsigned REPEAT_CYCLES     = 2_700_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef KEY_FILTER_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             r_sync1;
    logic             r_sync2;
    key_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rel_cnt;
    logic             r_was_long;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;

    logic             w_pressed;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_rel_inc;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // Counters saturate at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;
    assign w_rel_inc = (r_rel_cnt == '1) ? r_rel_cnt : r_rel_cnt + CNT_ONE;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rel_cnt  <= '0;
            r_was_long <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_rel_cnt <= '0;
                    if (w_pressed) begin
                        r_state <= PRESS_FILT;
                        r_cnt   <= CNT_ONE;
                    end
                end

                PRESS_FILT: begin
                    if (!w_pressed) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= DOWN;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                DOWN: begin
                    if (!w_pressed) begin
                        r_state    <= REL_FILT;
                        r_rel_cnt  <= CNT_ONE;
                        r_was_long <= 1'b0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= LONG_HELD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                LONG_HELD: begin
                    if (!w_pressed) begin
                        r_state    <= REL_FILT;
                        r_rel_cnt  <= CNT_ONE;
                        r_was_long <= 1'b1;
                    end
`ifdef KEY_FILTER_REPEAT_EN
                    else if (r_cnt == REP_LAST) begin
                        r_cnt  <= '0;
                        r_long <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end

                REL_FILT: begin
                    if (w_pressed) begin
                        // Bounce: resume the frozen hold count, counting this cycle as held.
                        r_rel_cnt <= '0;
                        if (r_was_long) begin
                            r_state <= LONG_HELD;
`ifdef KEY_FILTER_REPEAT_EN
                            if (r_cnt == REP_LAST) begin
                                r_cnt  <= '0;
                                r_long <= 1'b1;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
`endif
                        end else if (r_cnt == LONG_LAST) begin
                            r_state <= LONG_HELD;
                            r_cnt   <= '0;
                            r_long  <= 1'b1;
                        end else begin
                            r_state <= DOWN;
                            r_cnt   <= w_cnt_inc;
                        end
                    end else if (r_rel_cnt == DEB_LAST) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_rel_cnt  <= '0;
                        r_was_long <= 1'b0;
                        r_level    <= 1'b0;
                        r_release  <= 1'b1;
                    end else begin
                        r_rel_cnt <= w_rel_inc;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/key_filter.sv
// Multi-channel active-low key conditioner: one independent key_filter_ch per key pin.
// Optional auto-repeat of the long-press event: define KEY_FILTER_REPEAT_EN.
module key_filter
    import key_filter_pkg::*;
#(
    parameter int unsigned NUM_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 540_000,
    parameter int unsigned LONG_PRESS_CYCLES = 13_500_000,
    parameter int unsigned REPEAT_CYCLES     = 2_700_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_filter_ch #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES)
        ) u_ch (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .i_key_n  (key_n[g]),
            .o_level  (key_level[g]),
            .o_press  (key_press[g]),
            .o_release(key_release[g]),
            .o_long   (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with DEBOUNCE=8, LONG=40, REPEAT=10, two keys.
// Expected event times are relative to the pin edge that starts each scenario.
module tb_key_filter;

    localparam int NK  = 2;
    localparam int DEB = 8;
    localparam int LNG = 40;
    localparam int REP = 10;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [NK-1:0] key_n     = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    key_filter #(
        .NUM_KEYS         (NK),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LNG),
        .REPEAT_CYCLES    (REP)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;
    int t;
    int press_n[NK], press_t[NK], rel_n[NK], rel_t[NK];
    int long_n[NK], long_t[NK], long_last[NK];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        t = 0;
        for (int i = 0; i < NK; i++) begin
            press_n[i]   = 0;
            press_t[i]   = -1;
            rel_n[i]     = 0;
            rel_t[i]     = -1;
            long_n[i]    = 0;
            long_t[i]    = -1;
            long_last[i] = -1;
        end
    endtask

    // One clock edge, then sample the outputs and log events against edge index t.
    task automatic step();
        @(posedge sys_clk);
        #1;
        t++;
        for (int i = 0; i < NK; i++) begin
            if (key_press[i]) begin
                if (press_n[i] == 0) press_t[i] = t;
                press_n[i]++;
            end
            if (key_release[i]) begin
                if (rel_n[i] == 0) rel_t[i] = t;
                rel_n[i]++;
            end
            if (key_long[i]) begin
                if (long_n[i] == 0) long_t[i] = t;
                long_last[i] = t;
                long_n[i]++;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clear_log();

        // Reset state
        steps(3);
        check("rst_level",   int'(key_level),   0);
        check("rst_press",   int'(key_press),   0);
        check("rst_release", int'(key_release), 0);
        check("rst_long",    int'(key_long),    0);
        sys_rst_n = 1'b1;
        steps(2);

        // Clean press on key 0, held 20 cycles, then released
        clear_log();
        key_n[0] = 1'b0;
        steps(9);
        check("t1_level_before", int'(key_level[0]), 0);
        step();
        check("t1_press_pulse", int'(key_press[0]), 1);
        check("t1_level_up",    int'(key_level[0]), 1);
        step();
        check("t1_press_width", int'(key_press[0]), 0);
        steps(9);
        key_n[0] = 1'b1;
        steps(15);
        check("t1_press_n",  press_n[0], 1);
        check("t1_rel_t",    rel_t[0],   30);
        check("t1_rel_n",    rel_n[0],   1);
        check("t1_long_n",   long_n[0],  0);
        check("t1_level_dn", int'(key_level[0]), 0);

        // Press with bounce, then held ~100 cycles
        clear_log();
        key_n[0] = 1'b0;
        steps(5);
        key_n[0] = 1'b1;
        steps(2);
        key_n[0] = 1'b0;
        steps(110);
        key_n[0] = 1'b1;
        steps(18);
        check("t2_press_n", press_n[0], 1);
        check("t2_press_t", press_t[0], 17);
        check("t2_long_t",  long_t[0],  57);
`ifdef KEY_FILTER_REPEAT_EN
        check("t2_long_n",    long_n[0],    7);
        check("t2_long_last", long_last[0], 117);
`else
        check("t2_long_n",    long_n[0],    1);
        check("t2_long_last", long_last[0], 57);
`endif
        check("t2_rel_t", rel_t[0], 127);
        check("t2_rel_n", rel_n[0], 1);

        // Release bounce while in DOWN shifts key_long by the 3 frozen cycles
        clear_log();
        key_n[0] = 1'b0;
        steps(20);
        key_n[0] = 1'b1;
        steps(3);
        key_n[0] = 1'b0;
        steps(35);
        key_n[0] = 1'b1;
        steps(15);
        check("t3_press_n", press_n[0], 1);
        check("t3_long_t",  long_t[0],  53);
        check("t3_long_n",  long_n[0],  1);
        check("t3_rel_n",   rel_n[0],   1);
        check("t3_rel_t",   rel_t[0],   68);

        // Both keys together, staggered releases
        clear_log();
        key_n = 2'b00;
        steps(10);
        check("t4_press_both", int'(key_press), 3);
        check("t4_level_both", int'(key_level), 3);
        steps(10);
        key_n[0] = 1'b1;
        steps(5);
        key_n[1] = 1'b1;
        steps(15);
        check("t4_rel_t0",   rel_t[0],  30);
        check("t4_rel_t1",   rel_t[1],  35);
        check("t4_press_n1", press_n[1], 1);
        check("t4_long_n0",  long_n[0], 0);
        check("t4_long_n1",  long_n[1], 0);

        // Reset while key 0 is in LONG_HELD and still held
        clear_log();
        key_n[0] = 1'b0;
        steps(55);
        check("t5_long_before_rst", long_n[0], 1);
        sys_rst_n = 1'b0;
        #1;
        check("t5_rst_level", int'(key_level), 0);
        steps(3);
        check("t5_rst_all", int'({key_level, key_press, key_release, key_long}), 0);
        sys_rst_n = 1'b1;
        clear_log();
        steps(9);
        check("t5_level_before", int'(key_level[0]), 0);
        step();
        check("t5_press_pulse", int'(key_press[0]), 1);
        check("t5_level_up",    int'(key_level[0]), 1);
        check("t5_press_t",     press_t[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
